// File: rtl/alu_control_if.sv
// alu_control_if: decoder bus; master drives funct/ALUOp and reads saida/illegal, slave (decoder) does the reverse
interface alu_control_if;
  logic [5:0] funct;
  logic [1:0] ALUOp;
  logic [2:0] saida;
  logic       illegal;
  modport master(output funct, ALUOp, input saida, illegal);
  modport slave(input funct, ALUOp, output saida, illegal);
endinterface

// File: rtl/alu_control.sv
// alu_control: registered ALU select decoder; clock/reset (sync, active-high), bus.funct/ALUOp in, bus.saida/illegal out one cycle later
module alu_control #(
  parameter logic [2:0] DEFAULT_OP = 3'b010
) (
  input  logic         clock,
  input  logic         reset,
  alu_control_if.slave bus
);
  logic [2:0] saida_d, saida_q;
  logic       illegal_d, illegal_q;
  always_comb begin
    saida_d   = DEFAULT_OP;
    illegal_d = 1'b0;
    case (bus.ALUOp)
      2'b00: saida_d = 3'b010;
      2'b01: saida_d = 3'b110;
      2'b11: saida_d = 3'b001;
      2'b10:
        case (bus.funct)
          6'b100000: saida_d = 3'b010;
          6'b100010: saida_d = 3'b110;
          6'b100100: saida_d = 3'b000;
          6'b100101: saida_d = 3'b001;
          6'b101010: saida_d = 3'b111;
          default:   illegal_d = 1'b1;
        endcase
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_q   <= DEFAULT_OP;
      illegal_q <= 1'b0;
    end else begin
      saida_q   <= saida_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.saida   = saida_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: table-driven and hand-sequenced checks of the registered ALU control decoder
module tb_alu_control;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  alu_control_if bus ();
  alu_control dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] exp_saida;
    logic       exp_illegal;
    string      name;
  } vec_t;
  vec_t vecs [15];
  task automatic check(input string name, input logic [2:0] s, input logic il, input logic [2:0] es, input logic ei);
    total++;
    if (s === es && il === ei) passed++;
    else $display("FAIL %s: saida=%b illegal=%b, expected saida=%b illegal=%b", name, s, il, es, ei);
  endtask
  task automatic apply(input logic r, input logic [1:0] op, input logic [5:0] fn);
    reset = r;
    bus.ALUOp = op;
    bus.funct = fn;
    @(posedge clock);
    #1;
  endtask
  initial begin
    vecs[0]  = '{1'b1, 2'b10, 6'b100010, 3'b010, 1'b0, "reset_overrides_sub"};
    vecs[1]  = '{1'b0, 2'b10, 6'b100010, 3'b110, 1'b0, "after_reset_sub"};
    vecs[2]  = '{1'b0, 2'b00, 6'b101010, 3'b010, 1'b0, "aluop00_add"};
    vecs[3]  = '{1'b0, 2'b01, 6'b101010, 3'b110, 1'b0, "aluop01_sub"};
    vecs[4]  = '{1'b0, 2'b11, 6'b101010, 3'b001, 1'b0, "aluop11_or"};
    vecs[5]  = '{1'b0, 2'b10, 6'b100000, 3'b010, 1'b0, "rtype_add"};
    vecs[6]  = '{1'b0, 2'b10, 6'b100010, 3'b110, 1'b0, "rtype_sub"};
    vecs[7]  = '{1'b0, 2'b10, 6'b100100, 3'b000, 1'b0, "rtype_and"};
    vecs[8]  = '{1'b0, 2'b10, 6'b100101, 3'b001, 1'b0, "rtype_or"};
    vecs[9]  = '{1'b0, 2'b10, 6'b101010, 3'b111, 1'b0, "rtype_slt"};
    vecs[10] = '{1'b0, 2'b10, 6'b000000, 3'b010, 1'b1, "illegal_000000"};
    vecs[11] = '{1'b0, 2'b10, 6'b100000, 3'b010, 1'b0, "illegal_clears_add"};
    vecs[12] = '{1'b0, 2'b10, 6'b111111, 3'b010, 1'b1, "illegal_111111"};
    vecs[13] = '{1'b0, 2'b10, 6'b100100, 3'b000, 1'b0, "illegal_clears_and"};
    vecs[14] = '{1'b0, 2'b00, 6'b000000, 3'b010, 1'b0, "aluop00_ignores_bad_funct"};
    reset = 1'b1;
    bus.ALUOp = 2'b00;
    bus.funct = 6'b0;
    @(negedge clock);
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].fn);
      check(vecs[i].name, bus.saida, bus.illegal, vecs[i].exp_saida, vecs[i].exp_illegal);
    end
    apply(1'b0, 2'b10, 6'b100000);
    check("hold_pre", bus.saida, bus.illegal, 3'b010, 1'b0);
    bus.ALUOp = 2'b01;
    #3;
    check("hold_mid_cycle", bus.saida, bus.illegal, 3'b010, 1'b0);
    @(posedge clock);
    #1;
    check("hold_after_edge", bus.saida, bus.illegal, 3'b110, 1'b0);
    bus.ALUOp = 2'b10;
    bus.funct = 6'b101010;
    #3;
    check("hold_mid_cycle_rtype", bus.saida, bus.illegal, 3'b110, 1'b0);
    @(posedge clock);
    #1;
    check("hold_after_edge_slt", bus.saida, bus.illegal, 3'b111, 1'b0);
    apply(1'b0, 2'b10, 6'b100100);
    check("midreset_pre_and", bus.saida, bus.illegal, 3'b000, 1'b0);
    apply(1'b1, 2'b10, 6'b101010);
    check("midreset_discards_slt", bus.saida, bus.illegal, 3'b010, 1'b0);
    apply(1'b0, 2'b10, 6'b101010);
    check("midreset_resume_slt", bus.saida, bus.illegal, 3'b111, 1'b0);
    apply(1'b0, 2'b10, 6'b011111);
    check("illegal_before_reset", bus.saida, bus.illegal, 3'b010, 1'b1);
    apply(1'b1, 2'b10, 6'b011111);
    check("reset_clears_illegal", bus.saida, bus.illegal, 3'b010, 1'b0);
    apply(1'b0, 2'bxx, 6'b100010);
    check("unknown_aluop_default", bus.saida, bus.illegal, 3'b010, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
